l2_arbiter: RTL



---
 rtl/l2_arbiter_pkg.sv | 19 +
 rtl/l2_arbiter_if.sv | 44 ++++
 rtl/l2_arbiter_grant_sel.sv | 30 +++
 rtl/l2_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/l2_arbiter_pkg.sv
// Shared types and constants for the L1-to-L2 miss arbiter.
package rv32i_types;

  localparam int unsigned S_OFFSET = 5;
  localparam int unsigned S_LINE   = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

endpackage

// File: rtl/l2_arbiter_if.sv
// Bus bundle between the two L1 caches, the arbiter and the L2 port.
// master: arbiter view. slave: environment view (L1s plus L2).
interface l2_arbiter_if #(
  parameter int unsigned s_line = rv32i_types::S_LINE
) ();

  logic              icache_read;
  logic [31:0]       icache_address;
  logic [s_line-1:0] icache_rdata;
  logic              icache_resp;

  logic              dcache_read;
  logic              dcache_write;
  logic [31:0]       dcache_address;
  logic [s_line-1:0] dcache_wdata;
  logic [s_line-1:0] dcache_rdata;
  logic              dcache_resp;

  logic              l2_read;
  logic              l2_write;
  logic [31:0]       l2_address;
  logic [s_line-1:0] l2_wdata;
  logic [s_line-1:0] l2_rdata;
  logic              l2_resp;

  modport master (
    input  icache_read, icache_address,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  l2_rdata, l2_resp,
    output icache_rdata, icache_resp,
    output dcache_rdata, dcache_resp,
    output l2_read, l2_write, l2_address, l2_wdata
  );

  modport slave (
    output icache_read, icache_address,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    output l2_rdata, l2_resp,
    input  icache_rdata, icache_resp,
    input  dcache_rdata, dcache_resp,
    input  l2_read, l2_write, l2_address, l2_wdata
  );

endinterface

// File: rtl/l2_arbiter_grant_sel.sv
// Combinational grant selection between the I-cache and D-cache requests.
// ARB_ROUND_ROBIN_EN: alternate on ties using last_grant; otherwise D wins ties.
module arb_grant_sel
  import rv32i_types::*;
(
  input  logic      i_req,
  input  logic      d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  arb_port_t last_grant,
`endif
  output arb_port_t grant
);

  // Pick the winner; the result only matters when at least one request is up
  always_comb begin
    grant = PORT_D;
`ifdef ARB_ROUND_ROBIN_EN
    if (i_req && d_req) begin
      grant = (last_grant == PORT_D) ? PORT_I : PORT_D;
    end else if (i_req) begin
      grant = PORT_I;
    end
`else
    if (i_req && !d_req) begin
      grant = PORT_I;
    end
`endif
  end

endmodule

// File: rtl/l2_arbiter.sv
// L2 port arbiter: grants one L1 miss/writeback, holds it on L2 until l2_resp,
// then returns the line with a one-cycle resp pulse to the winner only.
// ARB_ROUND_ROBIN_EN selects round-robin tie breaking (default: D-cache priority).
module l2_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned s_offset = S_OFFSET,
  parameter int unsigned s_line   = S_LINE
) (
  input  logic         clk,
  input  logic         rst,
  l2_arbiter_if.master bus
);

  localparam logic [31:0] OFFSET_MASK = (32'd1 << s_offset) - 32'd1;

  arb_state_t        state;
  arb_port_t         grant;
  logic              i_req;
  logic              d_req;

  logic              l2_read_q;
  logic              l2_write_q;
  logic [31:0]       l2_address_q;
  logic [s_line-1:0] l2_wdata_q;
  logic [s_line-1:0] rdata_q;
  logic              icache_resp_q;
  logic              dcache_resp_q;

`ifdef ARB_ROUND_ROBIN_EN
  arb_port_t         last_grant;
`endif

  assign i_req = bus.icache_read;
  assign d_req = bus.dcache_read | bus.dcache_write;

  arb_grant_sel u_grant_sel (
    .i_req      (i_req),
    .d_req      (d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant (last_grant),
`endif
    .grant      (grant)
  );

  // Arbitration FSM; the l2_* registers double as the latched request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      l2_read_q     <= 1'b0;
      l2_write_q    <= 1'b0;
      l2_address_q  <= '0;
      l2_wdata_q    <= '0;
      rdata_q       <= '0;
      icache_resp_q <= 1'b0;
      dcache_resp_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant    <= PORT_D;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (i_req || d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= grant;
`endif
            if (grant == PORT_I) begin
              state        <= SERVE_I;
              l2_read_q    <= 1'b1;
              l2_write_q   <= 1'b0;
              l2_address_q <= bus.icache_address & ~OFFSET_MASK;
              l2_wdata_q   <= '0;
            end else begin
              // a write wins over a simultaneous (illegal) read
              state        <= SERVE_D;
              l2_read_q    <= ~bus.dcache_write;
              l2_write_q   <= bus.dcache_write;
              l2_address_q <= bus.dcache_address & ~OFFSET_MASK;
              l2_wdata_q   <= bus.dcache_write ? bus.dcache_wdata : '0;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.l2_resp) begin
            rdata_q       <= bus.l2_rdata;
            l2_read_q     <= 1'b0;
            l2_write_q    <= 1'b0;
            l2_address_q  <= '0;
            l2_wdata_q    <= '0;
            icache_resp_q <= (state == SERVE_I);
            dcache_resp_q <= (state == SERVE_D);
            state         <= RESP;
          end
        end
        RESP: begin
          icache_resp_q <= 1'b0;
          dcache_resp_q <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Flag an illegal simultaneous D-cache read and write at the point of grant
  always_ff @(posedge clk) begin
    if (rst && state == IDLE) begin
      assert (!(bus.dcache_read && bus.dcache_write))
        else $warning("l2_arbiter: dcache_read and dcache_write both high, write takes precedence");
    end
  end
`endif

  assign bus.l2_read      = l2_read_q;
  assign bus.l2_write     = l2_write_q;
  assign bus.l2_address   = l2_address_q;
  assign bus.l2_wdata     = l2_wdata_q;
  assign bus.icache_rdata = rdata_q;
  assign bus.dcache_rdata = rdata_q;
  assign bus.icache_resp  = icache_resp_q;
  assign bus.dcache_resp  = dcache_resp_q;

endmodule
